calc_scheduler: RTL and testbench

//  Shares one small_calc instance between N_REQ requesters. Picks one pending request

---
 rtl/calc_sched_pkg.sv | 22 ++
 rtl/calc_scheduler_rr_arbiter.sv | 36 +++
 rtl/calc_scheduler.sv | 164 ++++++++++++++++
 tb/tb_calc_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_sched_pkg.sv
// Shared constants for the calc scheduler: FSM encoding, small_calc opcodes
// and datapath widths.
package calc_sched_pkg;

  localparam int OP_W   = 2;
  localparam int OPND_W = 4;
  localparam int RES_W  = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  // Opcodes understood by small_calc; this block only forwards them.
  localparam logic [OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W-1:0] OP_AND = 2'd2;
  localparam logic [OP_W-1:0] OP_OR  = 2'd3;

endpackage

// File: rtl/calc_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first pending request at or after the
// pointer, wrapping around the top of the request vector.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] pos_s;
  logic          hit_s;

  // Walk N positions starting at ptr; the first pending one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum_s = '0;
    pos_s = '0;
    hit_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_s        = {1'b0, ptr} + (IW+1)'(i);
      pos_s        = (sum_s >= (IW+1)'(N)) ? IW'(sum_s - (IW+1)'(N)) : IW'(sum_s);
      hit_s        = !any && req[pos_s];
      idx          = hit_s ? pos_s : idx;
      grant[pos_s] = grant[pos_s] | hit_s;
      any          = any | hit_s;
    end
  end

endmodule

// File: rtl/calc_scheduler.sv
// Shares one small_calc between N_REQ requesters. A round-robin grant latches
// the winner's operands, pulses GO, waits for doneFlag (ignoring a stale done
// in the first wait cycle) and returns the result, or an error on timeout.
module calc_scheduler
  import calc_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [OP_W*N_REQ-1:0]     req_op,
  input  logic [OPND_W*N_REQ-1:0]   req_a,
  input  logic [OPND_W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic                      calc_go,
  output logic [OP_W-1:0]           calc_op,
  output logic [OPND_W-1:0]         calc_in1,
  output logic [OPND_W-1:0]         calc_in2,
  input  logic                      calc_done,
  input  logic [RES_W-1:0]          calc_out,
  output logic                      busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t              state_r;
  logic [IW-1:0]       rr_ptr_r;
  logic [IW-1:0]       grant_idx_r;
  logic [TW-1:0]       timer_r;
  logic                calc_go_r;
  logic [OP_W-1:0]     calc_op_r;
  logic [OPND_W-1:0]   calc_in1_r;
  logic [OPND_W-1:0]   calc_in2_r;
  logic [N_REQ-1:0]    rsp_valid_r;
  logic [RES_W-1:0]    rsp_data_r;
  logic                rsp_err_r;
  logic                busy_r;

  logic [N_REQ-1:0]    arb_grant_s;
  logic [IW-1:0]       arb_idx_s;
  logic                arb_any_s;
  logic [N_REQ-1:0]    rsp_oh_s;
  logic [IW-1:0]       next_ptr_s;

  logic [OP_W-1:0]     op_arr_s  [N_REQ];
  logic [OPND_W-1:0]   a_arr_s   [N_REQ];
  logic [OPND_W-1:0]   b_arr_s   [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_arr_s[g] = req_op[OP_W*g +: OP_W];
    assign a_arr_s[g]  = req_a[OPND_W*g +: OPND_W];
    assign b_arr_s[g]  = req_b[OPND_W*g +: OPND_W];
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (arb_grant_s),
    .idx   (arb_idx_s),
    .any   (arb_any_s)
  );

  assign rsp_oh_s   = N_REQ'(1) << grant_idx_r;
  assign next_ptr_s = (grant_idx_r == IW'(N_REQ - 1)) ? '0 : grant_idx_r + IW'(1);

  // Accept pulse goes out in the same IDLE cycle the grant is decided.
  always_comb begin
    req_ready = '0;
    if ((state_r == ST_IDLE) && !rst) begin
      req_ready = arb_grant_s;
    end else begin
      req_ready = '0;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign calc_go   = calc_go_r;
  assign calc_op   = calc_op_r;
  assign calc_in1  = calc_in1_r;
  assign calc_in2  = calc_in2_r;
  assign busy      = busy_r;

  // Transaction FSM: grant, issue GO, wait for done or timeout, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      grant_idx_r <= '0;
      timer_r     <= '0;
      calc_go_r   <= 1'b0;
      calc_op_r   <= '0;
      calc_in1_r  <= '0;
      calc_in2_r  <= '0;
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arb_any_s) begin
            state_r     <= ST_ISSUE;
            grant_idx_r <= arb_idx_s;
            calc_go_r   <= 1'b1;
            calc_op_r   <= op_arr_s[arb_idx_s];
            calc_in1_r  <= a_arr_s[arb_idx_s];
            calc_in2_r  <= b_arr_s[arb_idx_s];
            busy_r      <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          calc_go_r <= 1'b0;
          timer_r   <= '0;
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          // timer_r == 0 marks the first wait cycle, where done may be stale.
          if ((timer_r != '0) && calc_done) begin
            rsp_valid_r <= rsp_oh_s;
            rsp_data_r  <= calc_out;
            rsp_err_r   <= 1'b0;
            state_r     <= ST_RESP;
          end else if (timer_r == TW'(TIMEOUT - 1)) begin
            rsp_valid_r <= rsp_oh_s;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_RESP: begin
          rsp_valid_r <= '0;
          rsp_data_r  <= '0;
          rsp_err_r   <= 1'b0;
          calc_op_r   <= '0;
          calc_in1_r  <= '0;
          calc_in2_r  <= '0;
          timer_r     <= '0;
          busy_r      <= 1'b0;
          rr_ptr_r    <= next_ptr_s;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          calc_go_r   <= 1'b0;
          rsp_valid_r <= '0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_scheduler.sv
// Directed bench for calc_scheduler with a small_calc behavioural model.
// Stimulus pushes expected grants/responses; a negedge monitor pops and compares.
module tb_calc_scheduler;
  import calc_sched_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_op;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [4:0]     rsp_data;
  logic           rsp_err;
  logic           calc_go;
  logic [1:0]     calc_op;
  logic [3:0]     calc_in1;
  logic [3:0]     calc_in2;
  logic           calc_done;
  logic [4:0]     calc_out;
  logic           busy;

  calc_scheduler #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .calc_go(calc_go), .calc_op(calc_op),
    .calc_in1(calc_in1), .calc_in2(calc_in2), .calc_done(calc_done),
    .calc_out(calc_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [4:0] data;
    logic       err;
    int         delay;
  } exp_t;

  exp_t rsp_q[$];
  int   grant_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rdy_cyc  = -100;

  // small_calc model controls
  int         m_lat   = 2;
  bit         m_never = 1'b0;
  bit         m_stale = 1'b0;
  int         kcnt;
  logic [4:0] res_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] model_calc(input logic [1:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: kcnt counts cycles since GO (1 = first wait cycle); done is a level.
  always @(posedge clk) begin
    if (rst) begin
      kcnt  <= 0;
      res_r <= 5'd0;
    end else if (calc_go) begin
      kcnt  <= 1;
      res_r <= model_calc(calc_op, calc_in1, calc_in2);
    end else if (kcnt != 0 && kcnt < 100000) begin
      kcnt <= kcnt + 1;
    end
  end

  assign calc_done = !m_never && ((kcnt != 0 && kcnt >= m_lat) || (m_stale && kcnt == 1));
  assign calc_out  = (kcnt != 0 && kcnt >= m_lat) ? res_r :
                     ((m_stale && kcnt == 1) ? 5'd31 : 5'd0);

  // Monitor: compare every accept pulse, GO pulse and response against the queues.
  always @(negedge clk) begin
    if (req_ready != '0) begin
      if (grant_q.size() == 0) begin
        check("unexpected_ready", 32'(req_ready), 32'd0);
      end else begin
        int g;
        g = grant_q.pop_front();
        check("ready_grant", 32'(req_ready), 32'(1 << g));
        rdy_cyc <= cyc;
      end
    end
    if (calc_go === 1'b1) begin
      check("go_after_ready", 32'(cyc - rdy_cyc), 32'd1);
    end
    if (rsp_valid != '0) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = rsp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_latency", 32'(cyc - rdy_cyc), 32'(e.delay));
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b);
    req_op[2*i +: 2] = op;
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
  endtask

  task automatic expect_txn(input int idx, input logic [4:0] data, input logic err,
                            input int delay);
    exp_t e;
    e.idx = idx; e.data = data; e.err = err; e.delay = delay;
    grant_q.push_back(idx);
    rsp_q.push_back(e);
  endtask

  // Raise mask, hold until n accept pulses seen, then drop after the last one.
  task automatic do_req(input logic [N-1:0] mask, input int n);
    int got;
    got = 0;
    @(posedge clk); #1;
    req_valid = mask;
    for (int c = 0; c < 400 && got < n; c++) begin
      @(negedge clk);
      if (req_ready != '0) got++;
    end
    check("grant_count", 32'(got), 32'(n));
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("return_to_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_outputs", 32'({calc_go, rsp_valid, rsp_err, rsp_data, calc_op,
                                calc_in1, calc_in2, req_ready}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request: 3+5, done after 4 cycles
    m_lat = 4;
    set_req(0, OP_ADD, 4'd3, 4'd5);
    expect_txn(0, 5'd8, 1'b0, 6);
    do_req(4'b0001, 1);
    wait_idle();

    // Requester 3 alone, done rises in first wait cycle (captured in second)
    m_lat = 1;
    set_req(3, OP_AND, 4'd6, 4'd3);
    expect_txn(3, 5'd2, 1'b0, 4);
    do_req(4'b1000, 1);
    wait_idle();

    // All four requesting continuously from pointer 0
    m_lat = 2;
    set_req(0, OP_SUB, 4'd9, 4'd4);
    set_req(1, OP_AND, 4'd12, 4'd10);
    set_req(2, OP_OR, 4'd5, 4'd10);
    set_req(3, OP_ADD, 4'd15, 4'd15);
    expect_txn(0, 5'd5, 1'b0, 4);
    expect_txn(1, 5'd8, 1'b0, 4);
    expect_txn(2, 5'd15, 1'b0, 4);
    expect_txn(3, 5'd30, 1'b0, 4);
    expect_txn(0, 5'd5, 1'b0, 4);
    do_req(4'b1111, 5);
    wait_idle();

    // Move pointer to 2, then 0011 must wrap to 0 and then give 1
    expect_txn(1, 5'd8, 1'b0, 4);
    do_req(4'b0010, 1);
    wait_idle();
    expect_txn(0, 5'd5, 1'b0, 4);
    expect_txn(1, 5'd8, 1'b0, 4);
    do_req(4'b0011, 2);
    wait_idle();

    // Calculator never finishes: error response with zero data
    m_never = 1'b1;
    expect_txn(2, 5'd0, 1'b1, TMO + 2);
    do_req(4'b0100, 1);
    wait_idle();
    m_never = 1'b0;

    // Stale done with old result visible in the first wait cycle
    m_stale = 1'b1;
    m_lat   = 4;
    set_req(3, OP_ADD, 4'd7, 4'd6);
    expect_txn(3, 5'd13, 1'b0, 6);
    do_req(4'b1000, 1);
    wait_idle();
    m_stale = 1'b0;

    // Earliest capture in the second wait cycle, wrapping subtract
    m_lat = 2;
    set_req(1, OP_SUB, 4'd2, 4'd5);
    expect_txn(1, 5'd29, 1'b0, 4);
    do_req(4'b0010, 1);
    wait_idle();

    // Reset while waiting: no response, everything cleared, pointer back to 0
    m_never = 1'b1;
    grant_q.push_back(2);
    do_req(4'b0100, 1);
    @(posedge clk); #1;
    check("busy_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_never = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_outputs", 32'({calc_go, rsp_valid, rsp_err, rsp_data, calc_op,
                                   calc_in1, calc_in2}), 32'd0);
    repeat (4) @(negedge clk);

    m_lat = 3;
    set_req(0, OP_OR, 4'd8, 4'd1);
    expect_txn(0, 5'd9, 1'b0, 5);
    do_req(4'b1111, 1);
    wait_idle();

    repeat (3) @(negedge clk);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("grant_queue_drained", 32'(grant_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
